// File: rtl/rv32i_pkg.sv
// Shared constants and types for the RV32I memory-stage data access path.
package rv32i_pkg;

  localparam logic [1:0] FUNCT3_B = 2'b00;
  localparam logic [1:0] FUNCT3_H = 2'b01;
  localparam logic [1:0] FUNCT3_W = 2'b10;

  localparam int FUNCT3_UNS = 2;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} dmem_state_t;

endpackage

// File: rtl/rv32i_dmem_align.sv
// Byte-lane, store-data and split computation plus load extraction/extension.
module rv32i_dmem_align
  import rv32i_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [63:0] ldata,
  output logic [7:0]  m8,
  output logic [63:0] d64,
  output logic        span,
  output logic        illegal,
  output logic [31:0] rdata
);

  logic [3:0]  base;
  logic [2:0]  size;
  logic [31:0] r;
  logic        unused_top;

  // The largest load shift is 24 bits, so the top byte of {hi,lo} never lands in r.
  assign unused_top = ^ldata[63:56];

  always_comb begin
    base    = 4'b0000;
    size    = 3'd0;
    illegal = 1'b0;
    case (funct3[1:0])
      FUNCT3_B: begin base = MASK_B; size = 3'd1; end
      FUNCT3_H: begin base = MASK_H; size = 3'd2; end
      FUNCT3_W: begin base = MASK_W; size = 3'd4; end
      default:  illegal = 1'b1;
    endcase

    m8   = {4'b0000, base} << addr_lo;
    d64  = {32'b0, wdata} << {addr_lo, 3'b000};
    span = ({1'b0, addr_lo} + size) > 3'd4;

    case (addr_lo)
      2'd0:    r = ldata[31:0];
      2'd1:    r = ldata[39:8];
      2'd2:    r = ldata[47:16];
      default: r = ldata[55:24];
    endcase

    case (funct3[1:0])
      FUNCT3_B: rdata = funct3[FUNCT3_UNS] ? {24'b0, r[7:0]}  : {{24{r[7]}}, r[7:0]};
      FUNCT3_H: rdata = funct3[FUNCT3_UNS] ? {16'b0, r[15:0]} : {{16{r[15]}}, r[15:0]};
      default:  rdata = r;
    endcase
  end

endmodule

// File: rtl/rv32i_dmem_ctrl.sv
// Memory-stage sequencer: one load/store onto a Wishbone-style bus, split on word crossings.
//   state | meaning
//   IDLE  | waiting for a request; accepts and launches beat 0
//   BEAT0 | first (or only) aligned beat in flight
//   BEAT1 | second beat of a word-crossing access
//   RESP  | one-cycle o_done with registered o_rdata/o_err
module rv32i_dmem_ctrl
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT          = 255,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_dat,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_dat
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  dmem_state_t state;
  logic [31:0] a_addr;
  logic        a_we;
  logic [2:0]  a_funct3;
  logic        a_span;
  logic [3:0]  sel_hi;
  logic [31:0] dat_hi;
  logic [31:0] lo;
  logic [TW-1:0] tcnt;

  logic [1:0]  al_addr_lo;
  logic [2:0]  al_funct3;
  logic [63:0] al_ldata;
  logic [7:0]  m8;
  logic [63:0] d64;
  logic        span;
  logic        illegal;
  logic [31:0] ext_rdata;
  logic        timeout_hit;

  assign o_stall = i_req & ~o_done;

  // Launch uses the live request; load extraction uses the latched one.
  assign al_addr_lo = (state == IDLE) ? i_addr[1:0] : a_addr[1:0];
  assign al_funct3  = (state == IDLE) ? i_funct3    : a_funct3;
  assign al_ldata   = (state == BEAT1) ? {i_wb_dat, lo} : {32'b0, i_wb_dat};

  assign timeout_hit = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));

  rv32i_dmem_align u_align (
    .addr_lo (al_addr_lo),
    .funct3  (al_funct3),
    .wdata   (i_wdata),
    .ldata   (al_ldata),
    .m8      (m8),
    .d64     (d64),
    .span    (span),
    .illegal (illegal),
    .rdata   (ext_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      a_addr    <= '0;
      a_we      <= 1'b0;
      a_funct3  <= '0;
      a_span    <= 1'b0;
      sel_hi    <= '0;
      dat_hi    <= '0;
      lo        <= '0;
      tcnt      <= '0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_rdata   <= '0;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_we   <= 1'b0;
      o_wb_addr <= '0;
      o_wb_sel  <= '0;
      o_wb_dat  <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req) begin
            a_addr   <= i_addr;
            a_we     <= i_we;
            a_funct3 <= i_funct3;
            a_span   <= span;
            sel_hi   <= m8[7:4];
            dat_hi   <= d64[63:32];
            if (illegal || (span && !SPLIT_MISALIGNED)) begin
              state   <= RESP;
              o_done  <= 1'b1;
              o_err   <= 1'b1;
              o_rdata <= '0;
            end else begin
              state     <= BEAT0;
              tcnt      <= '0;
              o_wb_cyc  <= 1'b1;
              o_wb_stb  <= 1'b1;
              o_wb_we   <= i_we;
              o_wb_addr <= {i_addr[31:2], 2'b00};
              o_wb_sel  <= m8[3:0];
              o_wb_dat  <= d64[31:0];
            end
          end
        end
        BEAT0, BEAT1: begin
          if (i_wb_ack) begin
            lo <= i_wb_dat;
            if (state == BEAT0 && a_span) begin
              state     <= BEAT1;
              tcnt      <= '0;
              o_wb_addr <= {a_addr[31:2] + 30'd1, 2'b00};
              o_wb_sel  <= sel_hi;
              o_wb_dat  <= dat_hi;
            end else begin
              state    <= RESP;
              o_wb_cyc <= 1'b0;
              o_wb_stb <= 1'b0;
              o_done   <= 1'b1;
              o_err    <= 1'b0;
              o_rdata  <= a_we ? 32'b0 : ext_rdata;
            end
          end else if (timeout_hit) begin
            state    <= RESP;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_done   <= 1'b1;
            o_err    <= 1'b1;
            o_rdata  <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          o_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_dmem_ctrl.sv
// Directed bench for rv32i_dmem_ctrl with a simple wait-state Wishbone slave.
module tb_rv32i_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req2;
  logic        we;
  logic [31:0] addr;
  logic [2:0]  funct3;
  logic [31:0] wdata;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic        cyc, stb, wb_we;
  logic [31:0] wb_addr, wb_dat;
  logic [3:0]  wb_sel;
  logic        ack;
  logic [31:0] rdat;

  logic        stall2, done2, err2;
  logic [31:0] rdata2;
  logic        cyc2, stb2, wb_we2;
  logic [31:0] wb_addr2, wb_dat2;
  logic [3:0]  wb_sel2;

  int n_tests = 0;
  int n_fail  = 0;

  logic        ack_en;
  int          ack_wait;
  int          wcnt;
  logic [31:0] m_a0, m_d0, m_a1, m_d1;

  int          nb, stb_cnt;
  logic [31:0] b_addr [4];
  logic [3:0]  b_sel  [4];
  logic [31:0] b_dat  [4];
  logic        b_we   [4];
  logic        cyc2_seen;

  int          lat;
  logic        t_err;
  logic [31:0] t_rd;

  always #5 clk = ~clk;

  rv32i_dmem_ctrl #(.TIMEOUT(4), .SPLIT_MISALIGNED(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
    .i_funct3(funct3), .i_wdata(wdata), .o_stall(stall), .o_done(done),
    .o_err(err), .o_rdata(rdata), .o_wb_cyc(cyc), .o_wb_stb(stb),
    .o_wb_we(wb_we), .o_wb_addr(wb_addr), .o_wb_sel(wb_sel), .o_wb_dat(wb_dat),
    .i_wb_ack(ack), .i_wb_dat(rdat)
  );

  rv32i_dmem_ctrl #(.TIMEOUT(4), .SPLIT_MISALIGNED(1'b0)) dut_nosplit (
    .i_clk(clk), .i_rst(rst), .i_req(req2), .i_we(we), .i_addr(addr),
    .i_funct3(funct3), .i_wdata(wdata), .o_stall(stall2), .o_done(done2),
    .o_err(err2), .o_rdata(rdata2), .o_wb_cyc(cyc2), .o_wb_stb(stb2),
    .o_wb_we(wb_we2), .o_wb_addr(wb_addr2), .o_wb_sel(wb_sel2), .o_wb_dat(wb_dat2),
    .i_wb_ack(1'b0), .i_wb_dat(32'h0)
  );

  assign ack  = cyc && stb && ack_en && (wcnt >= ack_wait);
  assign rdat = (wb_addr == m_a0) ? m_d0 : (wb_addr == m_a1) ? m_d1 : 32'h0;

  always @(posedge clk) begin
    if (rst || !(cyc && stb) || ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  always @(posedge clk) begin
    if (cyc && stb) stb_cnt = stb_cnt + 1;
    if (ack && nb < 4) begin
      b_addr[nb] = wb_addr;
      b_sel[nb]  = wb_sel;
      b_dat[nb]  = wb_dat;
      b_we[nb]   = wb_we;
      nb = nb + 1;
    end
    if (cyc2) cyc2_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic txn(input logic t_we, input logic [31:0] a, input logic [2:0] f3,
                     input logic [31:0] wd, output int l, output logic e, output logic [31:0] rd);
    @(negedge clk);
    nb = 0; stb_cnt = 0;
    req = 1'b1; we = t_we; addr = a; funct3 = f3; wdata = wd;
    #1 chk("stall_req", {31'b0, stall}, 32'd1);
    l = 0; e = 1'bx; rd = 'x;
    for (int n = 2; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        l = n; e = err; rd = rdata;
        chk("stall_done", {31'b0, stall}, 32'd0);
        chk("cyc_at_done", {31'b0, cyc}, 32'd0);
        break;
      end
    end
    if (l == 0) chk("done_seen", {31'b0, done}, 32'd1);
    req = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; req2 = 1'b0; we = 1'b0; addr = '0; funct3 = '0; wdata = '0;
    ack_en = 1'b1; ack_wait = 0; nb = 0; stb_cnt = 0; cyc2_seen = 1'b0;
    m_a0 = 32'hFFFF_FFF0; m_d0 = '0; m_a1 = 32'hFFFF_FFF0; m_d1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc",   {31'b0, cyc},   32'd0);
    chk("rst_stb",   {31'b0, stb},   32'd0);
    chk("rst_done",  {31'b0, done},  32'd0);
    chk("rst_err",   {31'b0, err},   32'd0);
    chk("rst_rdata", rdata,          32'd0);
    chk("rst_addr",  wb_addr,        32'd0);
    chk("rst_sel",   {28'b0, wb_sel}, 32'd0);
    chk("rst_dat",   wb_dat,         32'd0);
    @(negedge clk); rst = 1'b0;

    // SW aligned word
    txn(1'b1, 32'h1000, 3'b010, 32'hDEADBEEF, lat, t_err, t_rd);
    chk("sw_lat", lat, 3);
    chk("sw_err", {31'b0, t_err}, 0);
    chk("sw_nb", nb, 1);
    chk("sw_addr", b_addr[0], 32'h1000);
    chk("sw_sel", {28'b0, b_sel[0]}, 32'hF);
    chk("sw_dat", b_dat[0], 32'hDEADBEEF);
    chk("sw_we", {31'b0, b_we[0]}, 1);
    chk("sw_rdata", t_rd, 0);

    // LB / LBU top byte
    m_a0 = 32'h1000; m_d0 = 32'h80FF_FF00;
    txn(1'b0, 32'h1003, 3'b000, 32'h0, lat, t_err, t_rd);
    chk("lb_lat", lat, 3);
    chk("lb_sel", {28'b0, b_sel[0]}, 32'h8);
    chk("lb_we", {31'b0, b_we[0]}, 0);
    chk("lb_rdata", t_rd, 32'hFFFF_FF80);
    txn(1'b0, 32'h1003, 3'b100, 32'h0, lat, t_err, t_rd);
    chk("lbu_rdata", t_rd, 32'h0000_0080);

    // SH crossing a word boundary
    txn(1'b1, 32'h1003, 3'b001, 32'h0000_ABCD, lat, t_err, t_rd);
    chk("sh_lat", lat, 4);
    chk("sh_nb", nb, 2);
    chk("sh_addr0", b_addr[0], 32'h1000);
    chk("sh_sel0", {28'b0, b_sel[0]}, 32'h8);
    chk("sh_dat0", b_dat[0], 32'hCD00_0000);
    chk("sh_addr1", b_addr[1], 32'h1004);
    chk("sh_sel1", {28'b0, b_sel[1]}, 32'h1);
    chk("sh_dat1", b_dat[1], 32'h0000_00AB);
    chk("sh_we1", {31'b0, b_we[1]}, 1);

    // LW split across 0x2000/0x2004
    m_a0 = 32'h2000; m_d0 = 32'h5678_1111; m_a1 = 32'h2004; m_d1 = 32'h2222_1234;
    txn(1'b0, 32'h2002, 3'b010, 32'h0, lat, t_err, t_rd);
    chk("lw_lat", lat, 4);
    chk("lw_err", {31'b0, t_err}, 0);
    chk("lw_addr0", b_addr[0], 32'h2000);
    chk("lw_sel0", {28'b0, b_sel[0]}, 32'hC);
    chk("lw_addr1", b_addr[1], 32'h2004);
    chk("lw_sel1", {28'b0, b_sel[1]}, 32'h3);
    chk("lw_rdata", t_rd, 32'h1234_5678);

    // LH / LHU aligned upper half
    m_a0 = 32'h3000; m_d0 = 32'h8001_7FFF;
    txn(1'b0, 32'h3002, 3'b001, 32'h0, lat, t_err, t_rd);
    chk("lh_sel", {28'b0, b_sel[0]}, 32'hC);
    chk("lh_rdata", t_rd, 32'hFFFF_8001);
    txn(1'b0, 32'h3002, 3'b101, 32'h0, lat, t_err, t_rd);
    chk("lhu_rdata", t_rd, 32'h0000_8001);

    // Ack on the final allowed cycle beats the timeout
    ack_wait = 3;
    txn(1'b0, 32'h3000, 3'b010, 32'h0, lat, t_err, t_rd);
    chk("lateack_lat", lat, 6);
    chk("lateack_err", {31'b0, t_err}, 0);
    chk("lateack_rdata", t_rd, 32'h8001_7FFF);
    ack_wait = 0;

    // No ack at all: timeout after four strobe cycles
    ack_en = 1'b0;
    txn(1'b0, 32'h4000, 3'b010, 32'h0, lat, t_err, t_rd);
    chk("to_stb_cycles", stb_cnt, 4);
    chk("to_lat", lat, 6);
    chk("to_err", {31'b0, t_err}, 1);
    ack_en = 1'b1;

    // Illegal funct3: immediate error, no bus cycle
    txn(1'b0, 32'h1000, 3'b011, 32'h0, lat, t_err, t_rd);
    chk("ill_lat", lat, 2);
    chk("ill_err", {31'b0, t_err}, 1);
    chk("ill_stb_cycles", stb_cnt, 0);

    // Non-splitting instance flags a misaligned word without touching the bus
    @(negedge clk);
    req2 = 1'b1; we = 1'b0; addr = 32'h2002; funct3 = 3'b010; cyc2_seen = 1'b0;
    lat = 0;
    for (int n = 2; n <= 20; n++) begin
      @(posedge clk); #1;
      if (done2) begin lat = n; t_err = err2; break; end
    end
    req2 = 1'b0;
    chk("nosplit_lat", lat, 2);
    chk("nosplit_err", {31'b0, t_err}, 1);
    @(posedge clk); #1;
    chk("nosplit_cyc", {31'b0, cyc2_seen}, 0);

    // Reset while beat 0 waits for ack
    ack_en = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h5000; funct3 = 3'b010; wdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    #1 chk("midrst_cyc_before", {31'b0, cyc}, 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_cyc", {31'b0, cyc}, 0);
    chk("midrst_stb", {31'b0, stb}, 0);
    chk("midrst_done", {31'b0, done}, 0);
    @(negedge clk); rst = 1'b0; req = 1'b0; ack_en = 1'b1;

    txn(1'b1, 32'h1000, 3'b010, 32'hCAFE_F00D, lat, t_err, t_rd);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_err", {31'b0, t_err}, 0);
    chk("post_rst_dat", b_dat[0], 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_dmem_ctrl.md
Name: rv32i_dmem_ctrl

Overview:
Memory-stage data-access sequencer. It takes one load/store request from the pipeline and drives it onto a single-master Wishbone-style data bus. It generates byte lanes and aligned store data, and sign- or zero-extends load data. Misaligned halfword/word accesses are split into two aligned bus beats. The pipeline stalls until the access completes, errors, or times out.

Parameters:
TIMEOUT, 255, ack-wait limit in cycles per beat; 0 disables the timeout.
SPLIT_MISALIGNED, 1, 1 = split accesses that cross a word boundary; 0 = flag them as errors with no bus cycle.

Ports:
i_clk  in  1  clock; all logic on rising edge.
i_rst  in  1  synchronous reset, active-high.
i_req  in  1  load/store request valid; held stable by the pipeline while o_stall=1.
i_we  in  1  1=store, 0=load.
i_addr  in  32  byte address from the ALU.
i_funct3  in  3  access width/sign: [1:0] 00=byte, 01=half, 10=word, 11=illegal; [2]=unsigned load.
i_wdata  in  32  store data (rs2).
o_stall  out  1  stall the pipeline.
o_done  out  1  one-cycle completion pulse.
o_err  out  1  valid with o_done: illegal funct3, misaligned with SPLIT_MISALIGNED=0, or timeout.
o_rdata  out  32  extended load data, valid with o_done.
o_wb_cyc  out  1  bus cycle.
o_wb_stb  out  1  bus strobe.
o_wb_we  out  1  bus write enable.
o_wb_addr  out  32  word-aligned address; bits [1:0] are always 0.
o_wb_sel  out  4  byte lanes {b3,b2,b1,b0}.
o_wb_dat  out  32  lane-aligned write data.
i_wb_ack  in  1  beat acknowledge.
i_wb_dat  in  32  read data, valid with ack.

Behaviour:
- Reset: state IDLE. All outputs are 0, including o_wb_*, o_rdata, o_done and o_err. The timeout counter is 0.
- Reset mid-operation: cyc/stb drop on the next edge and no o_done is issued. The bus slave must tolerate an abandoned cycle.
- States: IDLE, BEAT0, BEAT1, RESP.
- o_stall = i_req & ~o_done. It is combinational, and it covers the request cycle in IDLE.
- IDLE, with i_req:
  - Latch the request.
  - Compute span = (addr[1:0] + size) > 4, where size = 1, 2 or 4 bytes.
  - Illegal funct3, or span with SPLIT_MISALIGNED=0: go to RESP with err=1. No bus activity.
  - Otherwise go to BEAT0.
- BEAT0:
  - cyc = stb = 1; addr = {A[31:2], 2'b00}.
  - Let m8 = {4'b0, base_mask} << A[1:0], with base_mask = 0001, 0011 or 1111. Then sel = m8[3:0].
  - Let d64 = {32'b0, wdata} << 8*A[1:0]. Then dat = d64[31:0].
  - On ack: capture i_wb_dat into lo. If span, go to BEAT1; else go to RESP.
- BEAT1:
  - addr = {A[31:2]+1, 2'b00} (wraps modulo 2^32); sel = m8[7:4]; dat = d64[63:32].
  - cyc stays high between beats. stb stays high, but the address, sel and data change on the edge after ack.
  - On ack: capture i_wb_dat into hi, then go to RESP.
- Outputs stay constant while stb=1 and ack=0. Stores drive every beat with we=1; loads drive every beat with we=0.
- Load assembly: r = ({hi, lo} >> 8*A[1:0])[31:0]. hi = 0 when there is no split.
  - Byte: bit 7 extended unless funct3[2]=1.
  - Half: bit 15 extended unless funct3[2]=1.
  - Word: r unchanged.
  - Stores return o_rdata = 0.
- Timeout:
  - The counter clears when a beat starts and increments each cycle while stb=1 and ack=0.
  - When it reaches TIMEOUT, cyc/stb drop and the state goes to RESP with err=1.
  - An ack arriving in the same cycle as the timeout wins.
- RESP: o_done = 1 for exactly one cycle, with o_rdata and o_err registered. cyc = stb = 0. The next state is always IDLE.
- A new request is accepted only in IDLE, so back-to-back accesses have a one-cycle bubble.
- Latency from the accept edge, with zero-wait ack: aligned access gives o_done in cycle 3 (IDLE, BEAT0, RESP); split access gives o_done in cycle 4.

Decomposition:
- Shared package rv32i_pkg:
  - funct3 width codes: FUNCT3_B=2'b00, FUNCT3_H=2'b01, FUNCT3_W=2'b10.
  - Unsigned-load bit index (2).
  - Base masks for each width.
  - dmem_state_t enum {IDLE, BEAT0, BEAT1, RESP}.
- One combinational sub-module, rv32i_dmem_align. It computes m8, d64 and span from addr[1:0]/funct3/wdata, and load extension from {hi,lo}/addr[1:0]/funct3. The FSM, counter and registers stay in rv32i_dmem_ctrl.

Test Plan:
- SW, A=0x1000, wdata=0xDEADBEEF, zero-wait ack -> one beat: addr 0x1000, sel 1111, dat 0xDEADBEEF, we=1; o_done in cycle 3; o_err=0.
- LB, A=0x1003, bus returns 0x80FF_FF00 -> sel 1000; o_rdata 0xFFFFFF80. The same access as LBU gives 0x00000080.
- SH, A=0x1003, wdata=0x0000ABCD -> beat 0: addr 0x1000, sel 1000, dat[31:24]=0xCD. Beat 1: addr 0x1004, sel 0001, dat[7:0]=0xAB. o_done in cycle 4.
- LW, A=0x2002, bus returns 0x5678_xxxx then 0xxxxx_1234 -> two beats (0x2000, 0x2004); o_rdata 0x12345678. With SPLIT_MISALIGNED=0 -> no cyc, o_done with o_err=1.
- TIMEOUT=4, no ack -> stb held 4 cycles, then cyc/stb drop and o_done with o_err=1. funct3=3'b011 -> immediate o_err, no bus cycle.
- i_rst asserted in BEAT0 while waiting for ack -> next edge: cyc/stb/o_done = 0, state IDLE. A following SW completes normally.
